if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter IW, default 16: instruction word width, 8..32.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, power of two, 2..8.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port run  in  1  fetch enable; 0 means no new memory requests are issued.
REQ-006 Port redirect  in  1  branch/jump taken, single-cycle pulse.
REQ-007 Port redirect_pc  in  8  target address, valid when redirect=1.
REQ-008 Port imem_req  out  1  instruction memory request.
REQ-009 Port imem_addr  out  8  request address.
REQ-010 Port imem_ack  in  1  memory response; imem_data is valid in the same cycle.
REQ-011 Port imem_data  in  IW  instruction word.
REQ-012 Port ib_valid  out  1  buffer head valid toward decode.
REQ-013 Port ib_instr  out  IW  head instruction.
REQ-014 Port ib_pc  out  8  address of the head instruction.
REQ-015 Port ib_ready  in  1  decode accepts the head; pop = ib_valid & ib_ready.

Function
REQ-016 FSM states: IDLE, WAIT (request outstanding), DRAIN (outstanding request to be discarded).
REQ-017 imem_req SHALL be registered: 1 in WAIT/DRAIN, 0 in IDLE; imem_addr SHALL stay stable while imem_req=1 until the ack cycle.
REQ-018 IDLE->WAIT when run=1, redirect=0 and count-pop < DEPTH; imem_addr <= fetch_pc.
REQ-019 WAIT on ack (no redirect): push {imem_addr, imem_data}; fetch_pc <= imem_addr+1, wrapping 8'hFF->8'h00.
REQ-020 After an ack in WAIT, state stays WAIT with imem_addr <= imem_addr+1 (back-to-back) if run=1 and count+1-pop < DEPTH; otherwise go to IDLE.
REQ-021 Maximum one outstanding request; no push ever occurs when full; a push and pop in the same cycle at full is legal.
REQ-022 redirect in any state: flush buffer (count=0, ib_valid=0 next cycle); fetch_pc <= redirect_pc; flush takes priority over same-cycle push and pop.
REQ-023 redirect in WAIT with ack in the same cycle: discard the data and go to IDLE; without ack: go to DRAIN.
REQ-024 DRAIN holds imem_req=1 until ack, discards the data and goes to IDLE; a redirect in DRAIN updates fetch_pc only.
REQ-025 Fetch resumes at redirect_pc no earlier than the cycle after the state returns to IDLE.
REQ-026 run=0 blocks new requests only; an outstanding request still completes and pushes.
REQ-027 ib_instr and ib_pc SHALL read 0 whenever ib_valid=0.
REQ-028 Buffer order SHALL be FIFO; ib_pc values of consecutive entries increase by 1 mod 256 between redirects.

Reset
REQ-029 While rst=0: state IDLE; fetch_pc, imem_addr and the buffer pointers/count 0; imem_req 0; ib_valid 0; ib_instr/ib_pc 0.
REQ-030 Reset asserted mid-request SHALL abandon the request immediately; a late imem_ack after release is ignored in IDLE.

Configuration
REQ-031 Macro IF_FETCH_PERF_CNT_EN: when defined, add output stall_cnt (16 bits), reset 0, incremented each cycle with run=1, ib_ready=1 and ib_valid=0, saturating at 16'hFFFF, cleared by redirect.
REQ-032 Without IF_FETCH_PERF_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, run=1, memory acks 1 cycle after each request, ib_ready=1 -> ib_pc sequence 0,1,2,...; ib_instr matches the memory contents.
REQ-034 ib_ready=0, DEPTH=2 -> exactly 2 pushes (pc 0,1), then imem_req=0; raise ib_ready -> fetch resumes at pc 2.
REQ-035 redirect to 8'h40 while WAIT with ack 3 cycles later -> no push from that response, ib_valid=0, next imem_addr=8'h40.
REQ-036 fetch_pc=8'hFE, run=1 -> ib_pc 8'hFE, 8'hFF, 8'h00.
REQ-037 rst pulled low during WAIT -> imem_req=0 and ib_valid=0 at once; after release, first imem_addr=8'h00.
REQ-038 With IF_FETCH_PERF_CNT_EN, an empty buffer for 5 cycles with run=1 and ib_ready=1 -> stall_cnt=5; redirect -> 0.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit: one-outstanding memory requester feeding a FIFO buffer toward decode
// Optional stall counter output stall_cnt is built in when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch #(
    parameter int IW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          redirect,
    input  logic [7:0]    redirect_pc,
    output logic          imem_req,
    output logic [7:0]    imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic          ib_valid,
    output logic [IW-1:0] ib_instr,
    output logic [7:0]    ib_pc,
    input  logic          ib_ready
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    fetch_pc, fetch_pc_nxt, addr_nxt;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_pop;
    logic          pop, push;

    logic [IW-1:0] buf_instr [DEPTH];
    logic [7:0]    buf_pc    [DEPTH];

    assign ib_valid  = (count != '0);
    assign pop       = ib_valid & ib_ready;
    assign count_pop = count - {{(CW-1){1'b0}}, pop};
    assign ib_instr  = ib_valid ? buf_instr[rptr] : '0;
    assign ib_pc     = ib_valid ? buf_pc[rptr] : '0;

    // Space is judged after this cycle's pop so a full buffer being drained can still be refilled.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = imem_addr;
        push         = 1'b0;
        if (redirect) begin
            fetch_pc_nxt = redirect_pc;
        end
        case (state)
            IDLE: begin
                if (!redirect && run && (count_pop < FULL)) begin
                    state_nxt = WAIT;
                    addr_nxt  = fetch_pc;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_nxt = IDLE;
                    end else begin
                        push         = 1'b1;
                        fetch_pc_nxt = imem_addr + 8'd1;
                        if (run && (count_pop < LAST)) begin
                            addr_nxt = imem_addr + 8'd1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 8'd0;
            fetch_pc  <= 8'd0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            imem_req  <= (state_nxt != IDLE);
            imem_addr <= addr_nxt;
            fetch_pc  <= fetch_pc_nxt;
            if (redirect) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
                count <= count_pop + {{(CW-1){1'b0}}, push};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wptr] <= imem_data;
            buf_pc[wptr]    <= imem_addr;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (redirect) begin
            stall_cnt <= 16'd0;
        end else if (run && ib_ready && !ib_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized and directed bench for if_fetch against a queue-based fetch model
module tb_if_fetch;

    localparam int IW    = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          redirect;
    logic [7:0]    redirect_pc;
    logic          imem_req;
    logic [7:0]    imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          ib_valid;
    logic [IW-1:0] ib_instr;
    logic [7:0]    ib_pc;
    logic          ib_ready;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    if_fetch #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .ib_valid    (ib_valid),
        .ib_instr    (ib_instr),
        .ib_pc       (ib_pc),
        .ib_ready    (ib_ready)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] rom [256];

    // Memory model: acknowledges a held request after lat_min..lat_max extra cycles.
    int   lat_min = 1;
    int   lat_max = 1;
    int   cur_lat = 1;
    int   resp_cnt = 0;
    logic spur_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst || !imem_req) begin
            resp_cnt  = 0;
            imem_ack  = spur_en && ($urandom_range(7) == 0);
            imem_data = IW'($urandom);
        end else begin
            if (resp_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
            if (resp_cnt >= cur_lat) begin
                imem_ack  = 1'b1;
                imem_data = rom[imem_addr];
                resp_cnt  = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = IW'($urandom);
                resp_cnt++;
            end
        end
    end

    // Reference: expected buffer contents as a queue, plus the address the next request must use.
    logic [7:0]    qpc [$];
    logic [IW-1:0] qin [$];
    logic [7:0]    next_fetch;
    logic [7:0]    last_addr;
    logic          was_req, last_acked, discard, prev_run;
    logic          m_new, m_pop, m_acc;
    int            push_cnt = 0;
    logic [7:0]    pop_log [$];
    logic [7:0]    req_log [$];

    always @(negedge clk) begin
        if (!rst) begin
            qpc.delete();
            qin.delete();
            next_fetch = 8'd0;
            last_addr  = 8'd0;
            was_req    = 1'b0;
            last_acked = 1'b0;
            discard    = 1'b0;
            prev_run   = 1'b0;
        end else begin
            if (!ib_valid) begin
                check("empty_instr", 32'(ib_instr), 32'd0);
                check("empty_pc", 32'(ib_pc), 32'd0);
            end
            check("valid", 32'(ib_valid), 32'(qpc.size() != 0));
            if (ib_valid && qpc.size() != 0) begin
                check("head_pc", 32'(ib_pc), 32'(qpc[0]));
                check("head_instr", 32'(ib_instr), 32'(qin[0]));
            end
            m_new = imem_req && (!was_req || last_acked);
            if (m_new) begin
                check("req_addr", 32'(imem_addr), 32'(next_fetch));
                check("req_run", 32'(prev_run), 32'd1);
                req_log.push_back(imem_addr);
            end else if (imem_req) begin
                check("addr_stable", 32'(imem_addr), 32'(last_addr));
            end
            m_pop = ib_valid && ib_ready;
            m_acc = imem_req && imem_ack && !redirect && !discard;
            if (redirect) begin
                qpc.delete();
                qin.delete();
                next_fetch = redirect_pc;
            end else begin
                if (m_pop && qpc.size() != 0) begin
                    pop_log.push_back(ib_pc);
                    void'(qpc.pop_front());
                    void'(qin.pop_front());
                end
                if (m_acc) begin
                    qpc.push_back(imem_addr);
                    qin.push_back(rom[imem_addr]);
                    next_fetch = imem_addr + 8'd1;
                    push_cnt++;
                end
            end
            if (imem_req && imem_ack) discard = 1'b0;
            else if (redirect && imem_req) discard = 1'b1;
            check("occupancy", 32'(qpc.size() <= DEPTH), 32'd1);
            was_req    = imem_req;
            last_acked = imem_req && imem_ack;
            last_addr  = imem_addr;
            prev_run   = run;
        end
    end

    int p0, mr, mp;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
        rst = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = 8'd0; ib_ready = 1'b0;
        imem_ack = 1'b0; imem_data = '0;
        step(3);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(ib_valid), 32'd0);
        check("rst_instr", 32'(ib_instr), 32'd0);
        check("rst_pc", 32'(ib_pc), 32'd0);

        // Streaming from reset: pcs 0,1,2,...
        mp = pop_log.size();
        rst = 1'b1; run = 1'b1; ib_ready = 1'b1;
        step(30);
        check("stream_len", 32'(pop_log.size() >= mp + 5), 32'd1);
        if (pop_log.size() >= mp + 5)
            for (int i = 0; i < 5; i++) check("stream_pc", 32'(pop_log[mp+i]), 32'(i));

        // Decode stalled: exactly DEPTH pushes then idle; resumes at pc 2.
        rst = 1'b0; ib_ready = 1'b0;
        step(2);
        p0 = push_cnt;
        rst = 1'b1;
        step(20);
        check("full_pushes", 32'(push_cnt - p0), 32'd2);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(ib_valid), 32'd1);
        check("full_head", 32'(ib_pc), 32'd0);
        mr = req_log.size(); mp = pop_log.size();
        ib_ready = 1'b1;
        step(20);
        check("resume_len", 32'(req_log.size() > mr && pop_log.size() >= mp + 3), 32'd1);
        if (req_log.size() > mr) check("resume_addr", 32'(req_log[mr]), 32'd2);
        if (pop_log.size() >= mp + 3)
            for (int i = 0; i < 3; i++) check("resume_pc", 32'(pop_log[mp+i]), 32'(i));

        // Redirect while waiting, ack lands 3 cycles later and is dropped.
        run = 1'b0;
        step(10);
        lat_min = 3; lat_max = 3;
        run = 1'b1;
        step(1);
        check("redir_req0", 32'(imem_req), 32'd1);
        p0 = push_cnt;
        redirect = 1'b1; redirect_pc = 8'h40;
        step(1);
        redirect = 1'b0;
        step(3);
        check("redir_nopush", 32'(push_cnt - p0), 32'd0);
        check("redir_valid", 32'(ib_valid), 32'd0);
        check("redir_idle", 32'(imem_req), 32'd0);
        step(1);
        check("redir_req1", 32'(imem_req), 32'd1);
        check("redir_addr", 32'(imem_addr), 32'h40);

        // Address wrap FE, FF, 00.
        run = 1'b0;
        step(10);
        lat_min = 1; lat_max = 1;
        redirect = 1'b1; redirect_pc = 8'hFE;
        step(1);
        redirect = 1'b0;
        mp = pop_log.size();
        run = 1'b1;
        step(20);
        check("wrap_len", 32'(pop_log.size() >= mp + 3), 32'd1);
        if (pop_log.size() >= mp + 3) begin
            check("wrap_pc0", 32'(pop_log[mp]), 32'hFE);
            check("wrap_pc1", 32'(pop_log[mp+1]), 32'hFF);
            check("wrap_pc2", 32'(pop_log[mp+2]), 32'h00);
        end

        // Reset during an outstanding request with a non-empty buffer.
        run = 1'b0;
        step(10);
        lat_min = 3; lat_max = 3;
        ib_ready = 1'b0; run = 1'b1;
        step(7);
        check("pre_rst_req", 32'(imem_req), 32'd1);
        check("pre_rst_valid", 32'(ib_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_valid", 32'(ib_valid), 32'd0);
        step(2);
        mr = req_log.size();
        lat_min = 1; lat_max = 1; ib_ready = 1'b1;
        rst = 1'b1;
        step(10);
        check("post_rst_len", 32'(req_log.size() > mr), 32'd1);
        if (req_log.size() > mr) check("post_rst_addr", 32'(req_log[mr]), 32'd0);

        // Randomized traffic.
        spur_en = 1'b1; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            run      = ($urandom_range(3) != 0);
            ib_ready = ($urandom_range(4) < 3);
            if (!redirect && $urandom_range(19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 8'($urandom);
            end else begin
                redirect = 1'b0;
            end
            step(1);
        end
        redirect = 1'b0; spur_en = 1'b0;

`ifdef IF_FETCH_PERF_CNT_EN
        run = 1'b0; ib_ready = 1'b1;
        step(10);
        lat_min = 20; lat_max = 20;
        redirect = 1'b1; redirect_pc = 8'h10;
        step(1);
        redirect = 1'b0; run = 1'b1;
        step(5);
        check("stall_cnt5", 32'(stall_cnt), 32'd5);
        redirect = 1'b1;
        step(1);
        redirect = 1'b0;
        check("stall_clr", 32'(stall_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
